// File: rtl/piece_mover_if.sv
// Request/observation bundle between the game controller and piece_mover.
// The 145-bit vectors carry one bit per grid cell plus an unused top bit.
interface piece_mover_if #(
  parameter int W = 145
);
  logic         spawn;
  logic [W-1:0] spawnSqs;
  logic         btnLeft;
  logic         btnRight;
  logic         btnDown;
  logic [W-1:0] currentSqs;
  logic [W-1:0] backGround;
  logic         busy;
  logic         landed;
  logic [3:0]   linesCleared;
  logic         gameOver;

  modport slave (
    input  spawn, spawnSqs, btnLeft, btnRight, btnDown,
    output currentSqs, backGround, busy, landed, linesCleared, gameOver
  );

  modport master (
    output spawn, spawnSqs, btnLeft, btnRight, btnDown,
    input  currentSqs, backGround, busy, landed, linesCleared, gameOver
  );
endinterface

// File: rtl/piece_mover.sv
// Falling-piece and settled-playfield owner for the grid: spawn, moves,
// gravity, landing merge and bottom-up full-row clearing.
//
// state | meaning
// IDLE  | no piece; waiting for spawn
// FALL  | piece active; one lateral or down action per cycle
// MERGE | piece folded into background (landed pulse)
// CLEAR | row scan from bottom, collapsing full rows
// OVER  | spawn collided; held until reset
module piece_mover #(
  parameter int COLS     = 12,
  parameter int ROWS     = 12,
  parameter int DROP_DIV = 16
) (
  input logic           clk,
  input logic           resetn,
  piece_mover_if.slave  bus
);
  localparam int N  = COLS * ROWS;
  localparam int CW = $clog2(DROP_DIV);
  localparam int RW = $clog2(ROWS);

  typedef enum logic [2:0] {IDLE, FALL, MERGE, CLEAR, OVER} state_t;

  function automatic logic [N-1:0] col_mask(input int c);
    logic [N-1:0] m;
    m = '0;
    for (int r = 0; r < ROWS; r++) m[r*COLS + c] = 1'b1;
    return m;
  endfunction

  function automatic logic [N-1:0] row_mask(input int r);
    logic [N-1:0] m;
    m = '0;
    for (int c = 0; c < COLS; c++) m[r*COLS + c] = 1'b1;
    return m;
  endfunction

  localparam logic [N-1:0] COL_L = col_mask(0);
  localparam logic [N-1:0] COL_R = col_mask(COLS-1);
  localparam logic [N-1:0] ROW_B = row_mask(ROWS-1);

  state_t          state_q, state_d;
  logic [N-1:0]    cur_q, cur_d;
  logic [N-1:0]    bg_q, bg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pend_q, pend_d;
  logic [3:0]      lines_q, lines_d;
  logic [RW-1:0]   ptr_q, ptr_d;

  logic [N-1:0]    spawn_v;
  logic            tick, lat_req, pend_eff;
  logic            left_blk, right_blk, down_blk, row_full;
  logic [N-1:0]    low_m, shifted;

  assign spawn_v   = bus.spawnSqs[N-1:0];
  assign tick      = (cnt_q == CW'(DROP_DIV-1));
  assign lat_req   = bus.btnLeft ^ bus.btnRight;
  assign pend_eff  = pend_q | tick | bus.btnDown;
  assign left_blk  = (|(cur_q & COL_L)) | (|((cur_q >> 1) & bg_q));
  assign right_blk = (|(cur_q & COL_R)) | (|((cur_q << 1) & bg_q));
  assign down_blk  = (|(cur_q & ROW_B)) | (|((cur_q << COLS) & bg_q));
  assign row_full  = &bg_q[int'(ptr_q)*COLS +: COLS];

  // rows 0..ptr take the row above them; rows below the pointer are kept
  assign low_m   = {N{1'b1}} >> (COLS * (ROWS - 1 - int'(ptr_q)));
  assign shifted = ((bg_q << COLS) & low_m) | (bg_q & ~low_m);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cur_q   <= '0;
      bg_q    <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      lines_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      bg_q    <= bg_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      lines_q <= lines_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    bg_d    = bg_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    lines_d = lines_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (bus.spawn) begin
          if (|(spawn_v & bg_q)) begin
            state_d = OVER;
          end else begin
            cur_d   = spawn_v;
            cnt_d   = '0;
            pend_d  = 1'b0;
            state_d = FALL;
          end
        end
      end
      FALL: begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        if (lat_req) begin
          // a down request raised here waits for the next non-lateral cycle
          pend_d = pend_eff;
          if (bus.btnLeft && !left_blk)
            cur_d = cur_q >> 1;
          else if (bus.btnRight && !right_blk)
            cur_d = cur_q << 1;
        end else if (pend_eff) begin
          pend_d = 1'b0;
          if (down_blk) begin
            state_d = MERGE;
          end else begin
            cur_d = cur_q << COLS;
            cnt_d = '0;
          end
        end
      end
      MERGE: begin
        bg_d    = bg_q | cur_q;
        cur_d   = '0;
        lines_d = '0;
        ptr_d   = RW'(ROWS-1);
        state_d = CLEAR;
      end
      CLEAR: begin
        if (row_full) begin
          bg_d    = shifted;
          lines_d = (lines_q == 4'hF) ? lines_q : lines_q + 1'b1;
        end else if (ptr_q == '0) begin
          state_d = IDLE;
        end else begin
          ptr_d = ptr_q - 1'b1;
        end
      end
      OVER: ;
      default: state_d = IDLE;
    endcase
  end

  assign bus.currentSqs   = {1'b0, cur_q};
  assign bus.backGround   = {1'b0, bg_q};
  assign bus.busy         = (state_q == FALL) || (state_q == MERGE) || (state_q == CLEAR);
  assign bus.landed       = (state_q == MERGE);
  assign bus.linesCleared = lines_q;
  assign bus.gameOver     = (state_q == OVER);
endmodule

// File: tb/tb_piece_mover.sv
// Directed bench for piece_mover: expected values are queued as stimulus is
// applied and popped against the DUT outputs after each clock step.
module tb_piece_mover;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  piece_mover_if bus();
  piece_mover #(.COLS(12), .ROWS(12), .DROP_DIV(16)) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  typedef struct {
    string        tag;
    int           kind;
    logic [144:0] val;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  function automatic logic [144:0] c(input int i);
    logic [144:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [144:0] row(input int r);
    logic [144:0] v;
    v = '0;
    for (int k = 0; k < 12; k++) v[r*12 + k] = 1'b1;
    return v;
  endfunction

  function automatic logic [144:0] col(input int cc);
    logic [144:0] v;
    v = '0;
    for (int r = 0; r < 12; r++) v[r*12 + cc] = 1'b1;
    return v;
  endfunction

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // kind: 0 cur, 1 bg, 2 lines, 3 busy, 4 landed, 5 gameOver
  task automatic exp(input string tag, input int kind, input logic [144:0] v);
    exp_t e;
    e.tag = tag; e.kind = kind; e.val = v;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    logic [144:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        0:       obs = bus.currentSqs;
        1:       obs = bus.backGround;
        2:       obs = {141'b0, bus.linesCleared};
        3:       obs = {144'b0, bus.busy};
        4:       obs = {144'b0, bus.landed};
        5:       obs = {144'b0, bus.gameOver};
        default: obs = 'x;
      endcase
      total++;
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic clear_inputs();
    bus.spawn = 1'b0; bus.spawnSqs = '0;
    bus.btnLeft = 1'b0; bus.btnRight = 1'b0; bus.btnDown = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    resetn = 1'b0;
    step(1);
    resetn = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (bus.busy === 1'b1 && k < 60) begin
      step(1);
      k++;
    end
    total++;
    assert (bus.busy === 1'b0) else begin
      bad++;
      $error("FAIL %s_timeout busy=%b expected=0", tag, bus.busy);
    end
  endtask

  task automatic spawn_piece(input logic [144:0] p);
    bus.spawnSqs = p; bus.spawn = 1'b1;
    step(1);
    bus.spawn = 1'b0;
  endtask

  // spawn a pattern that already touches the floor/stack and land it at once
  task automatic place(input logic [144:0] p, input string tag);
    spawn_piece(p);
    bus.btnDown = 1'b1;
    step(1);
    bus.btnDown = 1'b0;
    wait_idle(tag);
  endtask

  logic [144:0] o_top, o_bot, pat;

  initial begin
    clear_inputs();
    #2;
    exp("rst_cur", 0, '0); exp("rst_bg", 1, '0); exp("rst_lines", 2, '0);
    exp("rst_busy", 3, '0); exp("rst_landed", 4, '0); exp("rst_over", 5, '0);
    check();
    @(posedge clk); #1;
    resetn = 1'b1;

    // gravity-only fall of an O-piece to the floor
    o_top = c(4) | c(5) | c(16) | c(17);
    o_bot = c(124) | c(125) | c(136) | c(137);
    spawn_piece(o_top);
    exp("o_spawn", 0, o_top); exp("o_busy", 3, 145'd1); check();
    step(15);
    exp("o_hold15", 0, o_top); check();
    step(1);
    exp("o_step1", 0, o_top << 12); check();
    step(16*9);
    exp("o_step10", 0, o_bot); check();
    step(16);
    exp("o_landed", 4, 145'd1); exp("o_cur_merge", 0, o_bot); check();
    step(1);
    exp("o_landed_off", 4, '0); exp("o_cur_clr", 0, '0);
    exp("o_bg", 1, o_bot); exp("o_busy_clr", 3, 145'd1); check();
    step(11);
    exp("o_scan_busy", 3, 145'd1); check();
    step(1);
    exp("o_idle", 3, '0); exp("o_bg_end", 1, o_bot); exp("o_lines", 2, '0); check();

    // walls and simultaneous buttons, lateral winning over a gravity tick
    do_reset();
    spawn_piece(c(0) | c(12));
    bus.btnLeft = 1'b1; step(1); bus.btnLeft = 1'b0;
    exp("wall_left", 0, c(0) | c(12)); check();
    bus.btnRight = 1'b1; step(1); bus.btnRight = 1'b0;
    exp("move_right", 0, c(1) | c(13)); check();
    bus.btnLeft = 1'b1; bus.btnRight = 1'b1; step(1);
    bus.btnLeft = 1'b0; bus.btnRight = 1'b0;
    exp("both_btn", 0, c(1) | c(13)); check();
    step(12);
    bus.btnRight = 1'b1; step(1); bus.btnRight = 1'b0;
    exp("tick_lat_first", 0, c(2) | c(14)); check();
    step(1);
    exp("tick_down_next", 0, c(14) | c(26)); check();

    // right blocked by settled column 2
    do_reset();
    place(col(2), "col2");
    exp("col2_bg", 1, col(2)); check();
    spawn_piece(c(1) | c(13));
    bus.btnRight = 1'b1; step(1); bus.btnRight = 1'b0;
    exp("bg_block_right", 0, c(1) | c(13)); check();
    step(14);
    bus.btnRight = 1'b1; step(1); bus.btnRight = 1'b0;
    exp("blk_tick_same", 0, c(1) | c(13)); check();
    step(1);
    exp("blk_tick_down", 0, c(13) | c(25)); check();

    // single row clear with a cell above shifting down
    do_reset();
    pat = (row(11) & ~c(137)) | c(123);
    place(pat, "row11");
    exp("row11_bg", 1, pat); check();
    spawn_piece(c(5));
    bus.btnDown = 1'b1; step(11); bus.btnDown = 1'b0;
    exp("drop_137", 0, c(137)); check();
    bus.btnDown = 1'b1; step(1); bus.btnDown = 1'b0;
    exp("one_landed", 4, 145'd1); check();
    step(1);
    exp("one_merged", 1, pat | c(137)); exp("one_lines0", 2, '0); check();
    step(1);
    exp("one_shift", 1, c(135)); exp("one_lines1", 2, 145'd1); check();
    wait_idle("one_clear");
    exp("one_final_bg", 1, c(135)); exp("one_final_lines", 2, 145'd1); check();

    // two rows completing together
    do_reset();
    pat = ((row(10) | row(11)) & ~c(125) & ~c(137)) | c(110);
    place(pat, "two_rows");
    spawn_piece(c(5) | c(17));
    bus.btnDown = 1'b1; step(10); bus.btnDown = 1'b0;
    exp("two_drop", 0, c(125) | c(137)); check();
    bus.btnDown = 1'b1; step(1); bus.btnDown = 1'b0;
    exp("two_landed", 4, 145'd1); check();
    wait_idle("two_clear");
    exp("two_lines", 2, 145'd2); exp("two_bg", 1, c(134)); check();

    // spawn collision ends the game; only reset recovers
    do_reset();
    place(col(5), "col5");
    spawn_piece(c(5));
    exp("over_flag", 5, 145'd1); exp("over_cur", 0, '0); exp("over_busy", 3, '0); check();
    spawn_piece(c(0));
    bus.btnLeft = 1'b1; step(1); bus.btnLeft = 1'b0;
    bus.btnDown = 1'b1; step(1); bus.btnDown = 1'b0;
    exp("over_hold", 5, 145'd1); exp("over_hold_cur", 0, '0);
    exp("over_hold_bg", 1, col(5)); check();
    resetn = 1'b0; #1;
    exp("over_rst_flag", 5, '0); exp("over_rst_bg", 1, '0); exp("over_rst_busy", 3, '0); check();
    step(1);
    resetn = 1'b1;

    // reset arriving mid-scan
    step(1);
    pat = row(11) | c(123);
    spawn_piece(pat);
    bus.btnDown = 1'b1; step(1); bus.btnDown = 1'b0;
    exp("clr_landed", 4, 145'd1); check();
    step(1);
    exp("clr_bg", 1, pat); check();
    resetn = 1'b0; #1;
    exp("clr_rst_bg", 1, '0); exp("clr_rst_cur", 0, '0);
    exp("clr_rst_busy", 3, '0); exp("clr_rst_lines", 2, '0); check();
    step(2);
    resetn = 1'b1;
    step(5);
    exp("clr_after_bg", 1, '0); exp("clr_after_busy", 3, '0);
    exp("clr_after_lines", 2, '0); check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
